dump_window_ctrl: RTL and testbench

Simulation/debug trigger controller that turns frame-level events into per-channel waveform-capture enables. It arms on a selectable condition (immediately, end of ROM download, or external trigger), counts frames from vertical-sync falling edges, and asserts CHANNELS independent dump windows [start, stop). The testbench top instantiates it, and its enables drive the probe-group dump on/off calls.

---
 rtl/dump_pkg.sv | 30 +++
 rtl/dump_sync2.sv | 33 +++
 rtl/dump_window_chan.sv | 59 +++++
 rtl/dump_window_ctrl.sv | 136 +++++++++++++
 tb/tb_dump_window_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dump_pkg.sv
// ============================================================================
// Module   : dump_pkg
// Purpose  : Shared types and defaults for the dump-window trigger controller.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dump_pkg;

  localparam int FW_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_DL = 3'd1,
    ARMED   = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_RST = 2'd0,
    MODE_DL  = 2'd1,
    MODE_EXT = 2'd2,
    MODE_OFF = 2'd3
  } mode_t;

endpackage

`default_nettype wire

// File: rtl/dump_sync2.sv
// ============================================================================
// Module   : dump_sync2
// Purpose  : Two-flop synchroniser for a single asynchronous level.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dump_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/dump_window_chan.sv
// ============================================================================
// Module   : dump_window_chan
// Purpose  : One probe-group window: [start, stop) compare, registered enable
//            and one-cycle on/off pulses taken from the enable edges.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dump_window_chan #(
  parameter int FW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic [FW-1:0] frame_cnt,
  input  logic [FW-1:0] start_frame,
  input  logic [FW-1:0] stop_frame,
  output logic          dump_en,
  output logic          dump_on,
  output logic          dump_off,
  output logic          closed,
  output logic          bounded
);

  logic w_open;
  logic w_win;
  logic r_en;
  logic r_en_q;
  logic r_on;
  logic r_off;

  assign w_open = (stop_frame == '0);
  assign w_win  = (frame_cnt >= start_frame) && (w_open || (frame_cnt < stop_frame));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_en_q <= 1'b0;
      r_on   <= 1'b0;
      r_off  <= 1'b0;
    end else begin
      r_en   <= active & w_win;
      r_en_q <= r_en;
      r_on   <= r_en & ~r_en_q;
      r_off  <= ~r_en & r_en_q;
    end
  end

  // Open-ended channels never hold up completion.
  assign closed   = w_open | (~r_en & (frame_cnt >= stop_frame));
  assign bounded  = ~w_open;
  assign dump_en  = r_en;
  assign dump_on  = r_on;
  assign dump_off = r_off;

endmodule

`default_nettype wire

// File: rtl/dump_window_ctrl.sv
// ============================================================================
// Module   : dump_window_ctrl
// Purpose  : Arms on a selectable condition, counts vsync falling edges and
//            drives per-channel waveform dump windows.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dump_window_ctrl
  import dump_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int FW       = FW_DEFAULT,
  parameter int DLWAIT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vs,
  input  logic                   downloading,
  input  logic                   ext_trig,
  input  logic [1:0]             mode,
  input  logic [CHANNELS*FW-1:0] start_frame,
  input  logic [CHANNELS*FW-1:0] stop_frame,
  output logic [FW-1:0]          frame_cnt,
  output logic                   armed,
  output logic [CHANNELS-1:0]    dump_en,
  output logic [CHANNELS-1:0]    dump_on,
  output logic [CHANNELS-1:0]    dump_off,
  output logic                   done
);

  localparam int                c_low_w  = $clog2(DLWAIT + 1);
  localparam logic [c_low_w-1:0] c_dlwait = c_low_w'(DLWAIT);

  state_t               r_state, w_state_nxt;
  mode_t                r_mode;
  logic                 w_vs_s, w_dl_s;
  logic                 r_vs_q, r_dl_q, r_ext_q;
  logic                 w_vs_fall, w_dl_rise, w_ext_rise;
  logic                 r_dl_seen;
  logic [c_low_w-1:0]   r_low_cnt;
  logic [FW-1:0]        r_frame_cnt;
  logic                 w_live, w_rearm;
  logic [CHANNELS-1:0]  w_closed, w_bounded;

  dump_sync2 u_sync_vs (.clk(clk), .rst_n(rst_n), .d(vs),          .q(w_vs_s));
  dump_sync2 u_sync_dl (.clk(clk), .rst_n(rst_n), .d(downloading), .q(w_dl_s));

  assign w_vs_fall  = r_vs_q & ~w_vs_s;
  assign w_dl_rise  = w_dl_s & ~r_dl_q;
  assign w_ext_rise = ext_trig & ~r_ext_q;
  assign w_live     = (r_state == ARMED) || (r_state == RUN);
  assign w_rearm    = (r_mode == MODE_DL) && w_dl_rise &&
                      (w_live || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= MODE_OFF;
      r_vs_q    <= 1'b0;
      r_dl_q    <= 1'b0;
      r_ext_q   <= 1'b0;
      r_dl_seen <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vs_q  <= w_vs_s;
      r_dl_q  <= w_dl_s;
      r_ext_q <= ext_trig;
      if (r_state == IDLE) r_mode <= mode_t'(mode);
      if (w_dl_s) r_dl_seen <= 1'b1;
      // Low time only counts once a download has actually been observed.
      if ((r_state != WAIT_DL) || w_dl_s || !r_dl_seen) r_low_cnt <= '0;
      else if (r_low_cnt != c_dlwait)                   r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_rearm || !(w_live || (r_state == DONE))) begin
      r_frame_cnt <= '0;
    end else if (w_live && w_vs_fall && !(&r_frame_cnt)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        case (mode_t'(mode))
          MODE_RST: w_state_nxt = ARMED;
          MODE_DL:  w_state_nxt = WAIT_DL;
          MODE_EXT: if (w_ext_rise) w_state_nxt = ARMED;
          default:  w_state_nxt = IDLE;
        endcase
      end
      WAIT_DL: if (r_low_cnt == c_dlwait) w_state_nxt = ARMED;
      ARMED: begin
        if (w_rearm)       w_state_nxt = WAIT_DL;
        else if (|dump_en) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_rearm)                           w_state_nxt = WAIT_DL;
        else if ((&w_closed) && (|w_bounded)) w_state_nxt = DONE;
      end
      DONE:    if (w_rearm) w_state_nxt = WAIT_DL;
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    dump_window_chan #(.FW(FW)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (w_live),
      .frame_cnt  (r_frame_cnt),
      .start_frame(start_frame[g*FW +: FW]),
      .stop_frame (stop_frame[g*FW +: FW]),
      .dump_en    (dump_en[g]),
      .dump_on    (dump_on[g]),
      .dump_off   (dump_off[g]),
      .closed     (w_closed[g]),
      .bounded    (w_bounded[g])
    );
  end

  assign frame_cnt = r_frame_cnt;
  assign armed     = w_live;
  assign done      = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dump_window_ctrl.sv
// ============================================================================
// Module   : tb_dump_window_ctrl
// Purpose  : Scoreboard bench: a frame-level window model queues expected
//            on/off/armed/done events, a monitor pops them as the DUT fires.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dump_window_ctrl;

  localparam int CH = 4;
  localparam int FW = 32;

  logic            clk = 1'b0;
  logic            rst_n, vs, downloading, ext_trig;
  logic [1:0]      mode;
  logic [CH*FW-1:0] start_frame, stop_frame;
  logic [FW-1:0]   frame_cnt;
  logic            armed, done;
  logic [CH-1:0]   dump_en, dump_on, dump_off;

  logic            rst4_n, ext4;
  logic [3:0]      start4, stop4, frame_cnt4;
  logic            armed4, done4;
  logic [0:0]      dump_en4, dump_on4, dump_off4;

  always #5 clk = ~clk;

  dump_window_ctrl #(.CHANNELS(CH), .FW(FW), .DLWAIT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading), .ext_trig(ext_trig),
    .mode(mode), .start_frame(start_frame), .stop_frame(stop_frame),
    .frame_cnt(frame_cnt), .armed(armed), .dump_en(dump_en), .dump_on(dump_on),
    .dump_off(dump_off), .done(done)
  );

  dump_window_ctrl #(.CHANNELS(1), .FW(4), .DLWAIT(16)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .vs(vs), .downloading(1'b0), .ext_trig(ext4),
    .mode(2'd2), .start_frame(start4), .stop_frame(stop4),
    .frame_cnt(frame_cnt4), .armed(armed4), .dump_en(dump_en4), .dump_on(dump_on4),
    .dump_off(dump_off4), .done(done4)
  );

  typedef struct {int kind; int frame; int cyc;} ev_t;  // kind: 0 on, 1 off, 2 armed, 3 done
  ev_t qch[CH][$];
  ev_t qctl[$];

  int  n_chk = 0, n_err = 0, cyc = 0, nf4 = 0;
  bit  dut4_live = 0;
  int  ms[CH], me[CH], mf;
  bit  mon[CH];
  bit  mlive, mdone, mrun;
  logic p_armed = 1'b0, p_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit win(input int c, input int f);
    return (f >= ms[c]) && (me[c] == 0 || f < me[c]);
  endfunction

  // ---------------- reference model (frame granularity) ----------------
  task automatic m_arm(input int exp_cyc);
    mf = 0; mlive = 1; mdone = 0; mrun = 0;
    qctl.push_back('{2, 0, exp_cyc});
    for (int c = 0; c < CH; c++) begin
      mon[c] = win(c, 0);
      if (mon[c]) begin qch[c].push_back('{0, 0, -1}); mrun = 1; end
    end
  endtask

  task automatic m_vsfall();
    bit w, any_b, all_b;
    if (!mlive || mdone) return;
    mf++;
    for (int c = 0; c < CH; c++) begin
      w = win(c, mf);
      if (w != mon[c]) qch[c].push_back('{w ? 0 : 1, mf, -1});
      mon[c] = w;
      if (w) mrun = 1;
    end
    any_b = 0; all_b = 1;
    for (int c = 0; c < CH; c++)
      if (me[c] != 0) begin any_b = 1; if (mf < me[c]) all_b = 0; end
    if (mrun && any_b && all_b) begin
      mdone = 1;
      qctl.push_back('{3, mf, -1});
      for (int c = 0; c < CH; c++) begin
        if (mon[c]) qch[c].push_back('{1, mf, -1});
        mon[c] = 0;
      end
    end
  endtask

  task automatic m_rearm();
    for (int c = 0; c < CH; c++) begin
      if (mon[c]) qch[c].push_back('{1, 0, -1});
      mon[c] = 0;
    end
    mlive = 0; mdone = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic vs_frame();
    vs = 1'b1; tick($urandom_range(4, 9));
    vs = 1'b0; m_vsfall(); if (dut4_live) nf4++;
    tick($urandom_range(4, 9));
  endtask

  task automatic set_cfg(input int s0, s1, s2, s3, e0, e1, e2, e3);
    ms = '{s0, s1, s2, s3}; me = '{e0, e1, e2, e3};
    for (int c = 0; c < CH; c++) begin
      start_frame[c*FW +: FW] = FW'(ms[c]);
      stop_frame[c*FW +: FW]  = FW'(me[c]);
    end
  endtask

  task automatic drain(input string tag);
    tick(8);
    for (int c = 0; c < CH; c++) chk({tag, "_pending_ch"}, qch[c].size(), 0);
    chk({tag, "_pending_ctl"}, qctl.size(), 0);
    qctl.delete();
    for (int c = 0; c < CH; c++) qch[c].delete();
  endtask

  task automatic do_reset(input logic [1:0] m, input string tag);
    drain(tag);
    rst_n = 1'b0; mode = m; downloading = 1'b0; ext_trig = 1'b0; vs = 1'b0;
    mlive = 0; mdone = 0;
    for (int c = 0; c < CH; c++) mon[c] = 0;
    tick(3);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0) ? dump_on[c] : dump_off[c]) begin
            n_chk++;
            if (qch[c].size() == 0) begin
              n_err++;
              $display("FAIL ch%0d_unexpected_%s: frame_cnt %0d, no event expected", c, k ? "off" : "on", frame_cnt);
            end else begin
              e = qch[c].pop_front();
              if (e.kind != k || e.frame != int'(frame_cnt)) begin
                n_err++;
                $display("FAIL ch%0d_event: got kind %0d at frame %0d, expected kind %0d at frame %0d", c, k, frame_cnt, e.kind, e.frame);
              end
            end
          end
        end
      end
      for (int k = 2; k < 4; k++) begin
        if ((k == 2) ? (armed && !p_armed) : (done && !p_done)) begin
          n_chk++;
          if (qctl.size() == 0) begin
            n_err++;
            $display("FAIL ctl_unexpected: kind %0d at cycle %0d frame %0d", k, cyc, frame_cnt);
          end else begin
            e = qctl.pop_front();
            if (e.kind != k || e.frame != int'(frame_cnt) || (e.cyc >= 0 && e.cyc != cyc)) begin
              n_err++;
              $display("FAIL ctl_event: got kind %0d frame %0d cycle %0d, expected kind %0d frame %0d cycle %0d", k, frame_cnt, cyc, e.kind, e.frame, e.cyc);
            end
          end
        end
      end
    end
    p_armed = armed;
    p_done  = done;
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; vs = 1'b0; downloading = 1'b0; ext_trig = 1'b0; mode = 2'd0;
    start_frame = '0; stop_frame = '0;
    rst4_n = 1'b0; ext4 = 1'b0; start4 = 4'd14; stop4 = 4'd0;
    #2;
    chk("reset_outputs", {frame_cnt, armed, dump_en, dump_on, dump_off, done}, 0);
    tick(3);
    rst4_n = 1'b1; tick(2); ext4 = 1'b1; tick(2); ext4 = 1'b0; dut4_live = 1;

    // mode 0, single window [2,5)
    do_reset(2'd0, "t1");
    set_cfg(2, 1, 1, 1, 5, 1, 1, 1);
    m_arm(cyc + 1); rst_n = 1'b1;
    repeat (8) vs_frame();
    chk("t1_frozen_cnt", frame_cnt, mf);
    chk("t1_done", done, 1);
    chk("t1_en_low", dump_en, 0);

    // mode 1, glitch then download end; mixed channel set
    do_reset(2'd0, "t2");
    mode = 2'd1;
    set_cfg(0, 3, 1, 4, 1, 3, 0, 6);
    rst_n = 1'b1;
    tick(40);
    downloading = 1'b1; tick(50);
    downloading = 1'b0; tick(10);
    downloading = 1'b1; tick(20);
    downloading = 1'b0; m_arm(cyc + 19);
    tick(25);
    repeat (8) vs_frame();
    chk("t2_frozen_cnt", frame_cnt, mf);
    chk("t2_open_ch2_off", dump_en[2], 0);

    // mode 1 re-arm at frame 7 with an open-ended channel
    do_reset(2'd1, "t3");
    set_cfg(2, 1, 3, 6, 5, 0, 4, 9);
    rst_n = 1'b1; tick(2);
    downloading = 1'b1; tick(30);
    downloading = 1'b0; m_arm(cyc + 19); tick(22);
    repeat (7) vs_frame();
    chk("t3_frame7", frame_cnt, 7);
    downloading = 1'b1; m_rearm(); tick(30);
    chk("t3_rearm_cnt", frame_cnt, 0);
    chk("t3_rearm_armed", armed, 0);
    downloading = 1'b0; m_arm(cyc + 19); tick(22);
    repeat (11) vs_frame();
    chk("t3_frozen_cnt", frame_cnt, mf);

    // mode 2, ext_trig lands on the same edge as a synced vs fall
    do_reset(2'd2, "t4");
    set_cfg(0, 1, 2, 0, 3, 2, 0, 0);
    rst_n = 1'b1; tick(4);
    vs = 1'b1; tick(6);
    vs = 1'b0; if (dut4_live) nf4++;
    tick(2);
    ext_trig = 1'b1; m_arm(cyc + 1);
    tick(3); ext_trig = 1'b0; tick(6);
    chk("t4_first_cnt", frame_cnt, 0);
    repeat (6) vs_frame();
    chk("t4_frozen_cnt", frame_cnt, mf);

    // randomized windows, mode 0
    for (int it = 0; it < 4; it++) begin
      do_reset(2'd0, "t5");
      set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8));
      m_arm(cyc + 1); rst_n = 1'b1;
      repeat (10) vs_frame();
      chk("t5_cnt", frame_cnt, mf);
      chk("t5_done", done, mdone);
    end

    // asynchronous reset in the middle of RUN
    do_reset(2'd0, "t6");
    set_cfg(0, 1, 2, 5, 0, 4, 0, 6);
    m_arm(cyc + 1); rst_n = 1'b1;
    repeat (3) vs_frame();
    drain("t6_mid");
    #2 rst_n = 1'b0;
    mlive = 0;
    for (int c = 0; c < CH; c++) mon[c] = 0;
    #1 chk("t6_async_reset", {frame_cnt, armed, dump_en, dump_on, dump_off, done}, 0);
    tick(3);
    m_arm(cyc + 1); rst_n = 1'b1;
    repeat (7) vs_frame();
    chk("t6_done", done, 1);
    chk("t6_cnt", frame_cnt, mf);

    drain("end");
    chk("sat_cnt", frame_cnt4, (nf4 > 15) ? 15 : nf4);
    chk("sat_en", dump_en4, (nf4 >= 14) ? 1 : 0);
    chk("sat_armed", armed4, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
